// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB-first.
// start/busy/done handshake; result is WIDTH cycles after acceptance.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_part_nx;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c    = (r_a[0] & r_b[0]) | (r_b[0] & r_c) | (r_a[0] & r_c);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // New bit enters at the MSB, so bit 0 ends up holding s_0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_part_nx = w_s;
        end else begin : g_wn
            assign w_part_nx = {w_s, r_part[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nx = S_RUN;
            S_RUN:   if (w_last) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_part <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_c   <= cin;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_c    <= w_c;
                    r_part <= w_part_nx;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_part_nx;
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH 8 vectors, WIDTH 4/1 sweeps.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s8, s4, s1;
    logic       ci8, ci4, ci1;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       a1, b1;
    logic       bz8, bz4, bz1;
    logic       dn8, dn4, dn1;
    logic       co8, co4, co1;
    logic [7:0] sm8;
    logic [3:0] sm4;
    logic       sm1;

    int n_chk = 0;
    int n_err = 0;
    int prev_s[9];
    int prev_c[9];

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(ci8),
        .busy(bz8), .done(dn8), .sum(sm8), .cout(co8)
    );
    serial_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .cin(ci4),
        .busy(bz4), .done(dn4), .sum(sm4), .cout(co4)
    );
    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(ci1),
        .busy(bz1), .done(dn1), .sum(sm1), .cout(co1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic c);
        case (w)
            8: begin s8 = st; a8 = av; b8 = bv; ci8 = c; end
            4: begin s4 = st; a4 = av[3:0]; b4 = bv[3:0]; ci4 = c; end
            default: begin s1 = st; a1 = av[0]; b1 = bv[0]; ci1 = c; end
        endcase
    endtask

    // {busy, done, cout, sum zero-extended to 8 bits}
    function automatic logic [10:0] outs(input int w);
        case (w)
            8: return {bz8, dn8, co8, sm8};
            4: return {bz4, dn4, co4, 4'b0, sm4};
            default: return {bz1, dn1, co1, 7'b0, sm1};
        endcase
    endfunction

    task automatic op(input int w, input int av, input int bv, input int ci,
                      input int es, input int ec, input bit glitch);
        logic [10:0] o;
        int lat;
        @(negedge clk);
        drive(w, 1'b1, 8'(av), 8'(bv), 1'(ci));
        @(negedge clk);
        drive(w, 1'b0, ~8'(av), ~8'(bv), ~1'(ci));
        o = outs(w);
        check("busy_acc", int'(o[10]), 1);
        check("done_acc", int'(o[9]), 0);
        check("hold_acc", int'(o[7:0]), prev_s[w]);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            o = outs(w);
            if (o[9]) break;
            check("hold_sum", int'(o[7:0]), prev_s[w]);
            check("hold_cout", int'(o[8]), prev_c[w]);
            if (glitch && lat == 2) drive(w, 1'b1, 8'hFF, 8'hFF, 1'b1);
            if (glitch && lat == 3) drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
        end
        check("latency", lat, w);
        check("busy_done", int'(o[10]), 1);
        check("sum", int'(o[7:0]), es);
        check("cout", int'(o[8]), ec);
        @(negedge clk);
        o = outs(w);
        check("done_pulse", int'(o[9]), 0);
        check("busy_idle", int'(o[10]), 0);
        check("sum_keep", int'(o[7:0]), es);
        prev_s[w] = es;
        prev_c[w] = ec;
    endtask

    function automatic int ca(input int n);
        return (n * 7 + 3) & 8'hFF;
    endfunction

    function automatic int cb(input int n);
        return (n * 13 + 5) & 8'hFF;
    endfunction

    initial begin
        logic [10:0] o;
        int t;
        foreach (prev_s[i]) begin
            prev_s[i] = 0;
            prev_c[i] = 0;
        end
        rst = 1'b1;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        o = outs(8);
        check("rst_busy", int'(o[10]), 0);
        check("rst_done", int'(o[9]), 0);
        check("rst_sum", int'(o[7:0]), 0);
        check("rst_cout", int'(o[8]), 0);
        rst = 1'b0;

        op(8, 'h3C, 'h0F, 0, 'h4B, 0, 1'b0);
        op(8, 'hFF, 'h01, 0, 'h00, 1, 1'b0);
        op(8, 'hFF, 'hFF, 1, 'hFF, 1, 1'b0);
        op(8, 'h00, 'h00, 1, 'h01, 0, 1'b0);
        op(8, 'h55, 'h0A, 0, 'h5F, 0, 1'b1);
        op(8, 'h3C, 'h0F, 0, 'h4B, 0, 1'b0);

        @(negedge clk);
        drive(8, 1'b1, 8'h11, 8'h22, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 8'h11, 8'h22, 1'b0);
        repeat (4) @(negedge clk);
        o = outs(8);
        check("mid_busy", int'(o[10]), 1);
        check("mid_sum", int'(o[7:0]), 'h4B);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = outs(8);
        check("abort_busy", int'(o[10]), 0);
        check("abort_done", int'(o[9]), 0);
        check("abort_sum", int'(o[7:0]), 0);
        check("abort_cout", int'(o[8]), 0);
        foreach (prev_s[i]) begin
            prev_s[i] = 0;
            prev_c[i] = 0;
        end
        repeat (12) begin
            @(negedge clk);
            o = outs(8);
            check("abort_nodone", int'(o[9]), 0);
        end
        op(8, 'h10, 'h20, 0, 'h30, 0, 1'b0);

        for (int n = 0; n <= 30; n++) begin
            @(negedge clk);
            if (n > 0) begin
                o = outs(8);
                check("cont_done", int'(o[9]), int'(n % 10 == 9));
                if (n % 10 == 9) begin
                    t = ca(n - 9) + cb(n - 9) + ((n - 9) & 1);
                    check("cont_sum", int'(o[7:0]), t & 'hFF);
                    check("cont_cout", int'(o[8]), (t >> 8) & 1);
                    prev_s[8] = t & 'hFF;
                    prev_c[8] = (t >> 8) & 1;
                end
            end
            if (n < 30) drive(8, 1'b1, 8'(ca(n)), 8'(cb(n)), 1'(n & 1));
            else drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        end
        @(negedge clk);
        check("cont_idle", int'(outs(8) >> 10), 0);

        for (int w = 1; w <= 4; w += 3) begin
            for (int x = 0; x < (1 << w); x++) begin
                for (int y = 0; y < (1 << w); y++) begin
                    for (int c = 0; c < 2; c++) begin
                        t = x + y + c;
                        op(w, x, y, c, t & ((1 << w) - 1), (t >> w) & 1, 1'b0);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder, the additive counterpart of the team's full-subtractor cell. It holds one full-adder bit slice (sum = a^b^c, carry = ab|bc|ac) and a carry flip-flop, and it processes the operands LSB-first, one bit per clock. It sits behind a start/busy/done handshake as an area-cheap arithmetic unit for datapaths where latency is acceptable.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH
cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk. rst has priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal operand shift registers, carry flop and bit counter are also 0.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: if start=1 at edge k:
  - latch a, b and cin (cin loads the carry flop)
  - clear the bit counter
  - go to RUN; busy=1 from edge k.
  - If start=0, remain in IDLE.
- RUN: at each edge, process bit i (i = counter value, 0..WIDTH-1):
  - s_i = a_sh[0]^b_sh[0]^c
  - c <= a_sh[0]&b_sh[0] | b_sh[0]&c | a_sh[0]&c
  - shift a_sh and b_sh right by 1; shift s_i into the MSB of the internal partial-result register
  - increment the counter.
  - At the edge processing bit WIDTH-1 (edge k+WIDTH): load sum from the completed partial result, load cout from the final carry, go to DONE.
- DONE: done=1 for exactly one cycle (after edge k+WIDTH through edge k+WIDTH+1), busy=1. The next edge returns to IDLE with done=0 and busy=0.
- Latency: the result is visible and done is high WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles.
- sum and cout change only on the DONE-entry edge or on reset. They hold the previous result throughout RUN and IDLE. The partial result is never visible on sum.
- start while in RUN or DONE is ignored: no restart, no re-latch, no queueing. It must be reasserted in IDLE.
- Input changes on a, b or cin after the accepting edge have no effect on the current operation.
- rst during RUN or DONE aborts the operation: no done pulse is issued, and sum/cout are cleared to 0.
- Counter width is clog2(WIDTH)+1 and must be correct for WIDTH=1. With WIDTH=1, RUN lasts exactly one cycle.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- WIDTH=8, a=0x3C, b=0x0F, cin=0, start pulsed at edge k -> busy from edge k; done high only in the cycle after edge k+8; sum=0x4B, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Hold start=1 continuously with changing a/b -> an operation is accepted only in IDLE, one per 10 cycles; each result matches the operands present at its accepting edge; done never lasts longer than 1 cycle.
- Mid-RUN (4 edges after start, previous sum=0x4B), assert rst for 1 cycle -> next cycle: IDLE, busy=0, sum=0, cout=0; no done pulse. A subsequent start a=0x10, b=0x20 -> sum=0x30.
- During RUN, change a/b and pulse start -> ignored; result reflects the originally latched operands; sum holds the old value until DONE.
- WIDTH=1 and WIDTH=4 instances: exhaustive sweep over a, b and cin against a+b+cin -> all results match; done arrives exactly WIDTH cycles after the accepting edge.
